// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared constants and FSM state encodings for the stopwatch
package stopwatch_pkg;

  localparam int              BCD_W      = 4;
  localparam int              NUM_DIGITS = 4;
  localparam logic [BCD_W-1:0] BCD_MAX   = 4'd9;

  // Control FSM encodings, kept here so the counter and bench share one definition
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    STOP  = 3'd2,
    INC   = 3'd3,
    TRAP  = 3'd4
  } sw_state_e;

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one BCD digit with carry-in/carry-out for a same-edge cascade
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter logic [BCD_W-1:0] MAX = BCD_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             cin,
  output logic [BCD_W-1:0] q,
  output logic             cout
);

  assign cout = cin && (q == MAX);

  // Any value at or above MAX (including corrupted ones) returns to 0 on the next carry-in
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (cin) begin
      q <= (q >= MAX) ? '0 : q + BCD_W'(1);
    end
  end

endmodule

// File: rtl/stopwatch_counter.sv
// rtl/stopwatch_counter.sv - prescaled SS.cc BCD elapsed-time counter with tick/ovf pulses
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int PRESCALE     = 10,
  parameter int SEC_TENS_MAX = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    time_en,
  input  logic                    clr,
  output logic [BCD_W-1:0]        dig0,
  output logic [BCD_W-1:0]        dig1,
  output logic [BCD_W-1:0]        dig2,
  output logic [BCD_W-1:0]        dig3,
  output logic [NUM_DIGITS*BCD_W-1:0] bcd,
  output logic                    tick,
  output logic                    ovf
);

  localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0]  pre;
  logic              tick_cond;
  logic [NUM_DIGITS:0] carry;
  logic [BCD_W-1:0]  digit_q [NUM_DIGITS];

  assign tick_cond = time_en && (pre == PRE_LAST);
  assign carry[0]  = tick_cond;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    localparam logic [BCD_W-1:0] DMAX = (i == NUM_DIGITS - 1) ? BCD_W'(SEC_TENS_MAX) : BCD_MAX;
    bcd_digit #(.MAX(DMAX)) u_digit (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .cin  (carry[i]),
      .q    (digit_q[i]),
      .cout (carry[i+1])
    );
  end

  // Prescaler holds while time_en is low so stop/start keeps sub-tick time
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre  <= '0;
      tick <= 1'b0;
      ovf  <= 1'b0;
    end else if (clr) begin
      pre  <= '0;
      tick <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      tick <= tick_cond;
      ovf  <= carry[NUM_DIGITS];
      if (time_en) begin
        pre <= tick_cond ? '0 : pre + PRE_W'(1);
      end
    end
  end

  assign dig0 = digit_q[0];
  assign dig1 = digit_q[1];
  assign dig2 = digit_q[2];
  assign dig3 = digit_q[3];
  assign bcd  = {dig3, dig2, dig1, dig0};

endmodule
